dma_priority_logic: RTL and testbench

Request arbiter for the four-channel DMA controller. It sits directly upstream of the timing-and-control block. It collects the DREQ lines and software requests, applies mask and polarity settings, picks one channel by fixed or rotating priority, and runs the HRQ/HLDA hold handshake with the host. When the hold is granted it asserts DACK and hands the granted channel to timing-and-control. It then holds DACK until timing-and-control reports end of service.

---
 rtl/dma_pkg.sv | 17 +
 rtl/dma_rotating_arbiter.sv | 28 ++
 rtl/dma_priority_logic.sv | 131 +++++++++++++
 tb/tb_dma_priority_logic.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA request arbiter.
package dma_pkg;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned CHAN_W   = 2;

  // 2-bit channel index
  typedef logic [CHAN_W-1:0] dma_chan_t;

  // Arbiter hold-handshake phases
  typedef enum logic [1:0] {
    PL_IDLE    = 2'd0,
    PL_REQ     = 2'd1,
    PL_SERVICE = 2'd2
  } pl_state_t;

endpackage

// File: rtl/dma_rotating_arbiter.sv
// Combinational rotating-priority picker: the channel just above lowPtr has
// the highest priority, lowPtr itself the lowest.
module dma_rotating_arbiter
  import dma_pkg::*;
(
  input  logic [3:0] req,
  input  dma_chan_t  lowPtr,
  output dma_chan_t  grantIdx,
  output logic       anyReq
);

  // Scan from lowest to highest priority so the highest-priority hit wins last
  always_comb begin
    dma_chan_t idx;
    idx      = '0;
    grantIdx = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = lowPtr + dma_chan_t'(i);
      if (req[idx]) begin
        grantIdx = idx;
      end
    end
  end

  // Any effective request present
  assign anyReq = |req;

endmodule

// File: rtl/dma_priority_logic.sv
// DMA request arbiter: qualifies DREQ/software requests, picks a channel by
// fixed or rotating priority and runs the HRQ/HLDA hold handshake.
module dma_priority_logic
  import dma_pkg::*;
#(
  parameter int unsigned CHANNELS = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [CHANNELS-1:0] DREQ,
  input  logic [CHANNELS-1:0] maskReg,
  input  logic [CHANNELS-1:0] swReq,
  input  logic                rotatingPriority,
  input  logic                dreqSenseLow,
  input  logic                dackSenseHigh,
  input  logic                controllerDisable,
  input  logic                HLDA,
  input  logic                serviceDone,
  output logic                HRQ,
  output logic [CHANNELS-1:0] DACK,
  output dma_chan_t           activeChannel,
  output logic                serviceValid,
  output logic [CHANNELS-1:0] reqPending
);

  logic [CHANNELS-1:0] dreq_reg;
  logic [CHANNELS-1:0] eff_req;
  logic [CHANNELS-1:0] dack_onehot;
  logic [CHANNELS-1:0] dack_onehot_d;
  pl_state_t           state;
  pl_state_t           state_d;
  logic                hrq_d;
  logic                service_valid_d;
  dma_chan_t           chan_d;
  dma_chan_t           low_ptr;
  dma_chan_t           low_ptr_d;
  dma_chan_t           grant_idx;
  logic                any_req;

  // Effective requests: polarity-corrected, masked DREQ plus unmaskable software requests
  assign eff_req    = ((dreq_reg ^ {CHANNELS{dreqSenseLow}}) & ~maskReg) | swReq;
  assign reqPending = eff_req;

  // Acknowledge polarity applied on the registered one-hot grant
  assign DACK = dack_onehot ^ {CHANNELS{~dackSenseHigh}};

  dma_rotating_arbiter u_arb (
    .req      (eff_req),
    .lowPtr   (low_ptr),
    .grantIdx (grant_idx),
    .anyReq   (any_req)
  );

  // State and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= PL_IDLE;
      HRQ           <= 1'b0;
      dack_onehot   <= '0;
      serviceValid  <= 1'b0;
      activeChannel <= '0;
      low_ptr       <= dma_chan_t'(3);
      dreq_reg      <= '0;
    end else begin
      state         <= state_d;
      HRQ           <= hrq_d;
      dack_onehot   <= dack_onehot_d;
      serviceValid  <= service_valid_d;
      activeChannel <= chan_d;
      low_ptr       <= low_ptr_d;
      dreq_reg      <= DREQ;
    end
  end

  // Next-state and next-output logic for the hold handshake
  always_comb begin
    state_d         = state;
    hrq_d           = HRQ;
    dack_onehot_d   = dack_onehot;
    service_valid_d = 1'b0;
    chan_d          = activeChannel;
    low_ptr_d       = low_ptr;

    case (state)
      PL_IDLE: begin
        if (any_req && !controllerDisable) begin
          chan_d  = grant_idx;
          hrq_d   = 1'b1;
          state_d = PL_REQ;
        end
      end
      PL_REQ: begin
        // Withdrawn request drops the hold; the winner is never pre-empted
        if (!eff_req[activeChannel]) begin
          hrq_d   = 1'b0;
          state_d = PL_IDLE;
        end else if (HLDA) begin
          dack_onehot_d   = CHANNELS'(1) << activeChannel;
          service_valid_d = 1'b1;
          state_d         = PL_SERVICE;
        end
      end
      PL_SERVICE: begin
        // Losing the bus outranks completion and leaves the pointer alone
        if (!HLDA) begin
          hrq_d         = 1'b0;
          dack_onehot_d = '0;
          state_d       = PL_IDLE;
        end else if (serviceDone) begin
          hrq_d         = 1'b0;
          dack_onehot_d = '0;
          state_d       = PL_IDLE;
          if (rotatingPriority) begin
            low_ptr_d = activeChannel;
          end
        end
      end
      default: begin
        hrq_d         = 1'b0;
        dack_onehot_d = '0;
        state_d       = PL_IDLE;
      end
    endcase

    // Fixed priority pins ch3 as lowest, i.e. ch0 highest
    if (!rotatingPriority) begin
      low_ptr_d = dma_chan_t'(3);
    end
  end

endmodule

// File: tb/tb_dma_priority_logic.sv
// Randomized and directed bench for dma_priority_logic against a cycle model.
module tb_dma_priority_logic;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic [3:0] maskReg;
  logic [3:0] swReq;
  logic       rotatingPriority;
  logic       dreqSenseLow;
  logic       dackSenseHigh;
  logic       controllerDisable;
  logic       HLDA;
  logic       serviceDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] activeChannel;
  logic       serviceValid;
  logic [3:0] reqPending;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: holding = HRQ high, serving = bus granted to m_chan
  logic [3:0] m_dq;
  bit         m_hrq;
  bit         m_serving;
  bit         m_sv;
  int         m_chan;
  int         m_ptr;

  dma_priority_logic dut (
    .CLK               (CLK),
    .RESET_N           (RESET_N),
    .DREQ              (DREQ),
    .maskReg           (maskReg),
    .swReq             (swReq),
    .rotatingPriority  (rotatingPriority),
    .dreqSenseLow      (dreqSenseLow),
    .dackSenseHigh     (dackSenseHigh),
    .controllerDisable (controllerDisable),
    .HLDA              (HLDA),
    .serviceDone       (serviceDone),
    .HRQ               (HRQ),
    .DACK              (DACK),
    .activeChannel     (activeChannel),
    .serviceValid      (serviceValid),
    .reqPending        (reqPending)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First requesting channel walking upward from the one after the lowest-priority one
  function automatic int winner(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  function automatic logic [3:0] exp_dack();
    logic [3:0] oh;
    oh = m_serving ? 4'(1 << m_chan) : 4'b0000;
    return oh ^ {4{~dackSenseHigh}};
  endfunction

  function automatic logic [3:0] idle_dack();
    return {4{~dackSenseHigh}};
  endfunction

  task automatic model_reset();
    m_dq = 4'b0; m_hrq = 0; m_serving = 0; m_sv = 0; m_chan = 0; m_ptr = 3;
  endtask

  // One clock: called at posedge+1 with inputs set; returns at next posedge+1
  task automatic tick();
    logic [3:0] eff;
    logic [3:0] n_dq;
    bit         n_hrq, n_serv, n_sv;
    int         n_chan, n_ptr;
    #2;
    eff = ((m_dq ^ {4{dreqSenseLow}}) & ~maskReg) | swReq;
    chk("reqPending", 32'(reqPending), 32'(eff));
    n_dq = DREQ; n_hrq = m_hrq; n_serv = m_serving; n_sv = 0;
    n_chan = m_chan; n_ptr = m_ptr;
    if (!m_hrq) begin
      if (eff != 4'b0 && !controllerDisable) begin
        n_chan = winner(eff, m_ptr);
        n_hrq  = 1;
      end
    end else if (!m_serving) begin
      if (!eff[m_chan]) n_hrq = 0;
      else if (HLDA) begin n_serv = 1; n_sv = 1; end
    end else if (!HLDA) begin
      n_hrq = 0; n_serv = 0;
    end else if (serviceDone) begin
      n_hrq = 0; n_serv = 0;
      if (rotatingPriority) n_ptr = m_chan;
    end
    if (!rotatingPriority) n_ptr = 3;
    @(posedge CLK);
    #1;
    m_dq = n_dq; m_hrq = n_hrq; m_serving = n_serv; m_sv = n_sv;
    m_chan = n_chan; m_ptr = n_ptr;
    chk("HRQ", 32'(HRQ), 32'(m_hrq));
    chk("DACK", 32'(DACK), 32'(exp_dack()));
    chk("activeChannel", 32'(activeChannel), 32'(m_chan));
    chk("serviceValid", 32'(serviceValid), 32'(m_sv));
  endtask

  // Asynchronous reset asserted between edges, released one edge later
  task automatic do_reset();
    #2;
    RESET_N = 1'b0;
    #1;
    model_reset();
    chk("rst_HRQ", 32'(HRQ), 32'(0));
    chk("rst_DACK", 32'(DACK), 32'(idle_dack()));
    chk("rst_serviceValid", 32'(serviceValid), 32'(0));
    chk("rst_activeChannel", 32'(activeChannel), 32'(0));
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic idle_inputs();
    DREQ = 4'b0; maskReg = 4'b0; swReq = 4'b0;
    controllerDisable = 1'b0; HLDA = 1'b0; serviceDone = 1'b0;
  endtask

  initial begin
    logic [3:0] grants [5];
    int         n_grants;
    int         cnt;

    RESET_N = 1'b0;
    idle_inputs();
    rotatingPriority = 1'b0;
    dreqSenseLow = 1'b0;
    dackSenseHigh = 1'b1;
    do_reset();

    // Fixed priority: ch1 beats ch3, HLDA follows HRQ by one cycle
    DREQ = 4'b1010;
    tick();
    chk("fix_hrq_edge_k", 32'(HRQ), 32'(0));
    tick();
    chk("fix_hrq_edge_k1", 32'(HRQ), 32'(1));
    chk("fix_chan", 32'(activeChannel), 32'(1));
    HLDA = 1'b1;
    tick();
    chk("fix_dack", 32'(DACK), 32'(4'b0010));
    chk("fix_sv_on", 32'(serviceValid), 32'(1));
    tick();
    chk("fix_sv_off", 32'(serviceValid), 32'(0));
    chk("fix_dack_hold", 32'(DACK), 32'(4'b0010));
    serviceDone = 1'b1;
    tick();
    chk("fix_release", 32'(DACK), 32'(4'b0000));
    idle_inputs();
    repeat (4) tick();

    // Rotating priority with all channels requesting
    rotatingPriority = 1'b1;
    DREQ = 4'b1111;
    n_grants = 0;
    cnt = 0;
    for (int c = 0; c < 80 && n_grants < 5; c++) begin
      HLDA = m_hrq;
      serviceDone = m_serving && (cnt == 3);
      tick();
      if (serviceValid === 1'b1) begin
        grants[n_grants] = DACK;
        n_grants++;
        cnt = 0;
      end else if (m_serving) begin
        cnt++;
      end
    end
    chk("rot_grant_count", 32'(n_grants), 32'(5));
    for (int g = 0; g < n_grants; g++) begin
      chk($sformatf("rot_grant%0d", g), 32'(grants[g]), 32'(4'b0001 << (g % 4)));
    end
    idle_inputs();
    repeat (4) tick();

    // Mask blocks DREQ, software request bypasses it
    rotatingPriority = 1'b0;
    maskReg = 4'b0001;
    DREQ = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("mask_hrq_low", 32'(HRQ), 32'(0));
    end
    swReq = 4'b0001;
    tick();
    chk("swreq_hrq", 32'(HRQ), 32'(1));
    idle_inputs();
    repeat (3) tick();

    // Polarity: active-low DREQ and DACK
    dreqSenseLow = 1'b1;
    dackSenseHigh = 1'b0;
    DREQ = 4'b1011;
    controllerDisable = 1'b1;
    do_reset();
    tick();
    chk("pol_dack_idle", 32'(DACK), 32'(4'b1111));
    controllerDisable = 1'b0;
    tick();
    chk("pol_chan", 32'(activeChannel), 32'(2));
    HLDA = 1'b1;
    tick();
    chk("pol_dack_service", 32'(DACK), 32'(4'b1011));
    serviceDone = 1'b1;
    tick();
    chk("pol_dack_done", 32'(DACK), 32'(4'b1111));
    idle_inputs();
    DREQ = 4'b1111;
    dreqSenseLow = 1'b0;
    dackSenseHigh = 1'b1;
    DREQ = 4'b0000;
    do_reset();

    // Bus lost on ch1 in rotating mode keeps the pointer
    rotatingPriority = 1'b1;
    DREQ = 4'b0110;
    tick();
    tick();
    chk("bus_chan", 32'(activeChannel), 32'(1));
    HLDA = 1'b1;
    tick();
    chk("bus_dack", 32'(DACK), 32'(4'b0010));
    tick();
    HLDA = 1'b0;
    tick();
    chk("bus_lost_dack", 32'(DACK), 32'(4'b0000));
    chk("bus_lost_hrq", 32'(HRQ), 32'(0));
    tick();
    chk("bus_regrant_chan", 32'(activeChannel), 32'(1));
    chk("bus_regrant_hrq", 32'(HRQ), 32'(1));
    HLDA = 1'b1;
    tick();
    chk("bus_regrant_dack", 32'(DACK), 32'(4'b0010));

    // Reset in the middle of a service; pointer returns to 3
    do_reset();
    DREQ = 4'b1111;
    HLDA = 1'b0;
    tick();
    tick();
    chk("post_rst_hrq", 32'(HRQ), 32'(1));
    chk("post_rst_chan", 32'(activeChannel), 32'(0));
    idle_inputs();

    // Randomized operation across polarity settings
    for (int blk = 0; blk < 3; blk++) begin
      dreqSenseLow = 1'($urandom_range(0, 1));
      dackSenseHigh = 1'($urandom_range(0, 1));
      rotatingPriority = 1'($urandom_range(0, 1));
      idle_inputs();
      do_reset();
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 3) == 0) DREQ = 4'($urandom);
        maskReg = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
        swReq = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
        if ($urandom_range(0, 49) == 0) rotatingPriority = ~rotatingPriority;
        controllerDisable = ($urandom_range(0, 9) == 0);
        HLDA = m_hrq ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
        serviceDone = ($urandom_range(0, 3) == 0);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
